// File: rtl/ray_sequencer.sv
// Steps one ray through every triangle ID, bounded by a credit counter that the
// accumulator's result-consumed pulses refill; ray_done marks the ray's last result.
//   state | meaning
//   IDLE  | waiting for a ray in the input FIFO
//   FETCH | ray FIFO read in flight, latch the ray
//   ISSUE | writing ray/triangle pairs, at most one every two cycles
//   DRAIN | every ID issued, waiting for outstanding results
module ray_sequencer #(
  parameter int D_BITS       = 32,
  parameter int M_BITS       = 12,
  parameter int NUM_TRI      = 1024,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ray_empty_i,
  output logic                   ray_rd_en_o,
  input  logic [5:0][D_BITS-1:0] ray_i,
  input  logic                   tri_full_i,
  output logic                   tri_wr_en_o,
  output logic [5:0][D_BITS-1:0] tri_ray_o,
  output logic [M_BITS-1:0]      tri_id_o,
  output logic                   tri_last_o,
  input  logic                   res_done_i,
  output logic                   ray_done_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int                CW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0]     MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [M_BITS-1:0] LAST_ID = M_BITS'(NUM_TRI - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;

  state_t                 state_q;
  logic [M_BITS-1:0]      next_id_q;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic                   err_q, err_d;
  logic                   ray_rd_en_q, tri_wr_en_q, tri_last_q, ray_done_q, busy_q;
  logic [5:0][D_BITS-1:0] tri_ray_q;
  logic [M_BITS-1:0]      tri_id_q;
  logic                   issue;

  // A write only goes out when the previous one has had a cycle to show up in tri_full.
  assign issue = (state_q == ISSUE) && !tri_full_i && !tri_wr_en_q && (inflight_q < MAX_CNT);

  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (issue && !res_done_i) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && res_done_i && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end
    if (res_done_i && (inflight_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      next_id_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      ray_rd_en_q <= 1'b0;
      tri_wr_en_q <= 1'b0;
      tri_last_q  <= 1'b0;
      ray_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      tri_ray_q   <= '0;
      tri_id_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
      ray_done_q <= 1'b0;
      tri_last_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ray_empty_i) begin
            ray_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          tri_ray_q   <= ray_i;
          ray_rd_en_q <= 1'b0;
          next_id_q   <= '0;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          if (issue) begin
            tri_wr_en_q <= 1'b1;
            tri_id_q    <= next_id_q;
            tri_last_q  <= (next_id_q == LAST_ID);
            next_id_q   <= next_id_q + 1'b1;
            if (next_id_q == LAST_ID) begin
              state_q <= DRAIN;
            end
          end else begin
            tri_wr_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          tri_wr_en_q <= 1'b0;
          if (inflight_q == '0) begin
            ray_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          // err survives recovery so a prior credit fault stays visible.
          state_q     <= IDLE;
          next_id_q   <= '0;
          ray_rd_en_q <= 1'b0;
          tri_wr_en_q <= 1'b0;
          busy_q      <= 1'b0;
          tri_ray_q   <= '0;
          tri_id_q    <= '0;
        end
      endcase
    end
  end

  assign ray_rd_en_o = ray_rd_en_q;
  assign tri_wr_en_o = tri_wr_en_q;
  assign tri_ray_o   = tri_ray_q;
  assign tri_id_o    = tri_id_q;
  assign tri_last_o  = tri_last_q;
  assign ray_done_o  = ray_done_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ray_sequencer.sv
// Bench for ray_sequencer: instance A (4 triangles, 8 credits) and instance B
// (4 triangles, 2 credits); expected writes are queued when a ray is offered.
module tb_ray_sequencer;

  typedef logic [5:0][31:0] ray_t;
  typedef struct {
    ray_t        ray;
    logic [11:0] id;
    logic        last;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ray_empty_a = 1'b1, ray_empty_b = 1'b1;
  logic        res_done_a = 1'b0, res_done_b = 1'b0;
  logic        tri_full = 1'b0;
  ray_t        ray_in = '0;

  logic        ray_rd_en_a, tri_wr_en_a, tri_last_a, ray_done_a, busy_a, err_a;
  ray_t        tri_ray_a;
  logic [11:0] tri_id_a;
  logic        ray_rd_en_b, tri_wr_en_b, tri_last_b, ray_done_b, busy_b, err_b;
  ray_t        tri_ray_b;
  logic [11:0] tri_id_b;

  exp_t sb_q[$];
  int   res_q[$];
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  int   t0, n_done, last_res;

  ray_sequencer #(.D_BITS(32), .M_BITS(12), .NUM_TRI(4), .MAX_INFLIGHT(8)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .ray_empty_i(ray_empty_a), .ray_rd_en_o(ray_rd_en_a),
    .ray_i(ray_in), .tri_full_i(tri_full), .tri_wr_en_o(tri_wr_en_a), .tri_ray_o(tri_ray_a),
    .tri_id_o(tri_id_a), .tri_last_o(tri_last_a), .res_done_i(res_done_a),
    .ray_done_o(ray_done_a), .busy_o(busy_a), .err_o(err_a)
  );

  ray_sequencer #(.D_BITS(32), .M_BITS(12), .NUM_TRI(4), .MAX_INFLIGHT(2)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .ray_empty_i(ray_empty_b), .ray_rd_en_o(ray_rd_en_b),
    .ray_i(ray_in), .tri_full_i(1'b0), .tri_wr_en_o(tri_wr_en_b), .tri_ray_o(tri_ray_b),
    .tri_id_o(tri_id_b), .tri_last_o(tri_last_b), .res_done_i(res_done_b),
    .ray_done_o(ray_done_b), .busy_o(busy_b), .err_o(err_b)
  );

  initial forever #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic ray_t rand_ray();
    ray_t r;
    for (int j = 0; j < 6; j++) r[j] = $urandom();
    return r;
  endfunction

  task automatic push_ray(input ray_t r);
    ray_in = r;
    for (int i = 0; i < 4; i++) sb_q.push_back('{ray: r, id: 12'(i), last: (i == 3)});
  endtask

  task automatic drive_res_a();
    res_done_a = 1'b0;
    if (res_q.size() > 0 && res_q[0] <= cyc) begin
      res_done_a = 1'b1;
      void'(res_q.pop_front());
      last_res = cyc + 1;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({ray_rd_en_a, tri_wr_en_a, tri_last_a, ray_done_a, busy_a, err_a, tri_id_a, tri_ray_a} !== '0)
      $display("FAIL reset_a: outputs %0h, expected all 0", {ray_rd_en_a, tri_wr_en_a, tri_last_a, ray_done_a, busy_a, err_a, tri_id_a});
    else n_pass++;
    n_checks++;
    if ({ray_rd_en_b, tri_wr_en_b, tri_last_b, ray_done_b, busy_b, err_b, tri_id_b, tri_ray_b} !== '0)
      $display("FAIL reset_b: outputs %0h, expected all 0", {ray_rd_en_b, tri_wr_en_b, tri_last_b, ray_done_b, busy_b, err_b, tri_id_b});
    else n_pass++;
    rst_ni = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({busy_a, ray_rd_en_a, tri_wr_en_a} !== 3'b000)
      $display("FAIL idle_after_reset: busy/rd/wr %b, expected 000", {busy_a, ray_rd_en_a, tri_wr_en_a});
    else n_pass++;
  endtask

  task automatic test_single();
    exp_t e;
    t0 = cyc; n_done = 0; last_res = -100;
    push_ray(rand_ray());
    ray_empty_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (ray_rd_en_a) begin
        ray_empty_a = 1'b1;
        n_checks++;
        if (cyc != t0 + 1) $display("FAIL single_rd_edge: rd_en at edge %0d, expected %0d", cyc - t0, 1);
        else n_pass++;
      end
      if (tri_wr_en_a) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL single_write: unexpected write id %0d", tri_id_a);
        else begin
          e = sb_q.pop_front();
          if ({tri_id_a, tri_last_a, tri_ray_a} !== {e.id, e.last, e.ray} || cyc != t0 + 3 + 2 * int'(e.id))
            $display("FAIL single_write: id %0d last %b edge %0d ray %h, expected id %0d last %b edge %0d ray %h",
                     tri_id_a, tri_last_a, cyc - t0, tri_ray_a, e.id, e.last, 3 + 2 * int'(e.id), e.ray);
          else n_pass++;
          res_q.push_back(cyc + 4);
        end
      end else if (tri_last_a) begin
        n_checks++;
        $display("FAIL single_last: tri_last 1 without tri_wr_en, expected 0");
      end
      if (ray_done_a) begin
        n_done++;
        n_checks++;
        if (cyc != last_res + 1) $display("FAIL single_done_edge: ray_done at edge %0d, expected %0d", cyc - t0, last_res + 1 - t0);
        else n_pass++;
      end
      drive_res_a();
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL single_missing: %0d writes outstanding, expected 0", sb_q.size());
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL single_done_count: %0d ray_done pulses, expected 1", n_done);
    else n_pass++;
    n_checks++;
    if ({err_a, busy_a} !== 2'b00) $display("FAIL single_end: err/busy %b, expected 00", {err_a, busy_a});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    t0 = cyc; n_done = 0; last_res = -100;
    push_ray(rand_ray());
    ray_empty_a = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (ray_rd_en_a) ray_empty_a = 1'b1;
      if (tri_wr_en_a) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL simul_write: unexpected write id %0d", tri_id_a);
        else begin
          e = sb_q.pop_front();
          if ({tri_id_a, tri_last_a, tri_ray_a} !== {e.id, e.last, e.ray} || cyc != t0 + 3 + 2 * int'(e.id))
            $display("FAIL simul_write: id %0d last %b edge %0d, expected id %0d last %b edge %0d",
                     tri_id_a, tri_last_a, cyc - t0, e.id, e.last, 3 + 2 * int'(e.id));
          else n_pass++;
          res_q.push_back(cyc + 1);
        end
      end
      if (ray_done_a) begin
        n_done++;
        n_checks++;
        if (cyc != t0 + 12) $display("FAIL simul_done_edge: ray_done at edge %0d, expected 12", cyc - t0);
        else n_pass++;
      end
      drive_res_a();
    end
    n_checks++;
    if (n_done != 1 || sb_q.size() != 0)
      $display("FAIL simul_end: done %0d outstanding %0d, expected 1 and 0", n_done, sb_q.size());
    else n_pass++;
    n_checks++;
    if (err_a !== 1'b0) $display("FAIL simul_err: err %b, expected 0", err_a);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic full_seen;
    int   exp_edge [4];
    exp_edge[0] = 3; exp_edge[1] = 12; exp_edge[2] = 14; exp_edge[3] = 16;
    t0 = cyc; n_done = 0; last_res = -100;
    push_ray(rand_ray());
    ray_empty_a = 1'b0;
    for (int k = 0; k < 35; k++) begin
      step();
      full_seen = tri_full;
      if (ray_rd_en_a) ray_empty_a = 1'b1;
      if (tri_wr_en_a) begin
        n_checks++;
        if (full_seen) $display("FAIL bp_write_while_full: write id %0d with tri_full sampled 1, expected none", tri_id_a);
        else if (sb_q.size() == 0) $display("FAIL bp_write: unexpected write id %0d", tri_id_a);
        else begin
          e = sb_q.pop_front();
          if ({tri_id_a, tri_last_a, tri_ray_a} !== {e.id, e.last, e.ray} || cyc != t0 + exp_edge[e.id[1:0]])
            $display("FAIL bp_write: id %0d last %b edge %0d, expected id %0d last %b edge %0d",
                     tri_id_a, tri_last_a, cyc - t0, e.id, e.last, exp_edge[e.id[1:0]]);
          else n_pass++;
          res_q.push_back(cyc + 3);
        end
      end
      if (cyc == t0 + 8) begin
        n_checks++;
        if ({tri_wr_en_a, tri_id_a} !== 13'd0)
          $display("FAIL bp_hold: wr %b id %0d during stall, expected wr 0 id 0", tri_wr_en_a, tri_id_a);
        else n_pass++;
      end
      if (ray_done_a) n_done++;
      tri_full = (cyc >= t0 + 4) && (cyc <= t0 + 10);
      drive_res_a();
    end
    n_checks++;
    if (n_done != 1 || sb_q.size() != 0)
      $display("FAIL bp_end: done %0d outstanding %0d, expected 1 and 0", n_done, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_credit_stall();
    exp_t e;
    int   exp_edge [4];
    exp_edge[0] = 3; exp_edge[1] = 5; exp_edge[2] = 21; exp_edge[3] = 25;
    t0 = cyc; n_done = 0;
    push_ray(rand_ray());
    ray_empty_b = 1'b0;
    for (int k = 0; k < 45; k++) begin
      step();
      if (ray_rd_en_b) ray_empty_b = 1'b1;
      if (tri_wr_en_b) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL credit_write: unexpected write id %0d", tri_id_b);
        else begin
          e = sb_q.pop_front();
          if ({tri_id_b, tri_last_b, tri_ray_b} !== {e.id, e.last, e.ray} || cyc != t0 + exp_edge[e.id[1:0]])
            $display("FAIL credit_write: id %0d last %b edge %0d, expected id %0d last %b edge %0d",
                     tri_id_b, tri_last_b, cyc - t0, e.id, e.last, exp_edge[e.id[1:0]]);
          else n_pass++;
        end
      end
      if (ray_done_b) begin
        n_done++;
        n_checks++;
        if (cyc != t0 + 33) $display("FAIL credit_done_edge: ray_done at edge %0d, expected 33", cyc - t0);
        else n_pass++;
      end
      res_done_b = (cyc == t0 + 19) || (cyc == t0 + 23) || (cyc == t0 + 27) || (cyc == t0 + 31);
    end
    n_checks++;
    if (n_done != 1 || sb_q.size() != 0 || err_b !== 1'b0)
      $display("FAIL credit_end: done %0d outstanding %0d err %b, expected 1, 0, 0", n_done, sb_q.size(), err_b);
    else n_pass++;
  endtask

  task automatic test_spurious();
    exp_t e;
    res_done_a = 1'b1;
    step();
    res_done_a = 1'b0;
    n_checks++;
    if (err_a !== 1'b1) $display("FAIL spurious_err: err %b, expected 1", err_a);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if ({err_a, busy_a} !== 2'b10) $display("FAIL spurious_hold: err/busy %b, expected 10", {err_a, busy_a});
    else n_pass++;
    t0 = cyc; n_done = 0; last_res = -100;
    push_ray(rand_ray());
    ray_empty_a = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (ray_rd_en_a) ray_empty_a = 1'b1;
      if (tri_wr_en_a) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL spurious_write: unexpected write id %0d", tri_id_a);
        else begin
          e = sb_q.pop_front();
          if ({tri_id_a, tri_last_a, tri_ray_a} !== {e.id, e.last, e.ray} || cyc != t0 + 3 + 2 * int'(e.id))
            $display("FAIL spurious_write: id %0d last %b edge %0d, expected id %0d last %b edge %0d",
                     tri_id_a, tri_last_a, cyc - t0, e.id, e.last, 3 + 2 * int'(e.id));
          else n_pass++;
          res_q.push_back(cyc + 2);
        end
      end
      if (ray_done_a) begin
        n_done++;
        n_checks++;
        if (cyc != t0 + 13) $display("FAIL spurious_done_edge: ray_done at edge %0d, expected 13", cyc - t0);
        else n_pass++;
      end
      drive_res_a();
    end
    n_checks++;
    if (n_done != 1 || sb_q.size() != 0 || err_a !== 1'b1)
      $display("FAIL spurious_end: done %0d outstanding %0d err %b, expected 1, 0, 1", n_done, sb_q.size(), err_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid_ray();
    exp_t e;
    int   tbase;
    bit   did_reset;
    did_reset = 1'b0;
    t0 = cyc; tbase = t0; n_done = 0; last_res = -100;
    push_ray(rand_ray());
    ray_empty_a = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ray_rd_en_a) ray_empty_a = 1'b1;
      if (tri_wr_en_a) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL rst_write: unexpected write id %0d", tri_id_a);
        else begin
          e = sb_q.pop_front();
          if ({tri_id_a, tri_last_a, tri_ray_a} !== {e.id, e.last, e.ray} || cyc != tbase + 3 + 2 * int'(e.id))
            $display("FAIL rst_write: id %0d last %b edge %0d, expected id %0d last %b edge %0d",
                     tri_id_a, tri_last_a, cyc - tbase, e.id, e.last, 3 + 2 * int'(e.id));
          else n_pass++;
          res_q.push_back(cyc + 2);
          if (!did_reset && e.id == 12'd2) begin
            did_reset = 1'b1;
            rst_ni = 1'b0;
            #1;
            n_checks++;
            if ({ray_rd_en_a, tri_wr_en_a, tri_last_a, ray_done_a, busy_a, err_a, tri_id_a, tri_ray_a} !== '0)
              $display("FAIL rst_async: outputs %0h, expected all 0", {ray_rd_en_a, tri_wr_en_a, tri_last_a, ray_done_a, busy_a, err_a, tri_id_a});
            else n_pass++;
            sb_q.delete();
            res_q.delete();
            res_done_a = 1'b0;
            push_ray(rand_ray());
            ray_empty_a = 1'b0;
            step();
            n_checks++;
            if ({ray_rd_en_a, tri_wr_en_a, busy_a, tri_id_a, tri_ray_a} !== '0)
              $display("FAIL rst_hold: rd/wr/busy %b id %0d, expected 000 id 0", {ray_rd_en_a, tri_wr_en_a, busy_a}, tri_id_a);
            else n_pass++;
            rst_ni = 1'b1;
            tbase = cyc;
            n_done = 0;
          end
        end
      end
      if (ray_done_a) n_done++;
      drive_res_a();
    end
    n_checks++;
    if (n_done != 1 || sb_q.size() != 0 || !did_reset)
      $display("FAIL rst_end: done %0d outstanding %0d reset_hit %b, expected 1, 0, 1", n_done, sb_q.size(), did_reset);
    else n_pass++;
    n_checks++;
    if (err_a !== 1'b0) $display("FAIL rst_err: err %b, expected 0", err_a);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_credit_stall();
    test_spurious();
    test_reset_mid_ray();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
